odliczanie_n_cylindrow: RTL and testbench
=========================================

# odliczanie_n_cylindrow

Parametrised crank-angle timebase for an N-cylinder four-stroke engine driver. It derives one 720° cycle position counter per cylinder from a single prescaled master tick, with the cylinders phase-shifted by 720°/N_CYL. It also counts completed cycles per cylinder and flags each cylinder's cycle wrap. It sits between the RPM-to-timing converter, which supplies clocks-per-degree, and the per-cylinder ignition/injection comparators, which consume the angle counters.

## Interface
Parameters:
- N_CYL, 4: number of cylinders; legal values 1, 2, 4, 8.
- PRESC, 1000: clocks per angle tick; must be ≥ 2.
- TPD_W, 9: width of taktowanie_na_stopien.
- TICK_W, 29: width of each angle counter.
- REV_W, 4: width of each cycle counter.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rozruch  in  1  start request; level-sampled in IDLE.
- zatrzymanie  in  1  stop request; returns to IDLE.
- sygnal_zmiany_rpm  in  1  resync request: relatch period and restart all cylinders.
- taktowanie_na_stopien  in  TPD_W  angle ticks per degree.
- licznik  out  N_CYL*TICK_W  packed angle counters; cylinder k occupies [k*TICK_W +: TICK_W].
- zliczanie_obrotow  out  N_CYL*REV_W  packed completed-cycle counters.
- aktywny  out  N_CYL  cylinder k counter is running.
- znacznik_gmp  out  N_CYL  one-clock pulse on each cylinder's cycle wrap.

## Operation
- Period: P = taktowanie_na_stopien × 720, held in a (TPD_W+10)-bit register.
  - P is latched only on the IDLE→RUN transition and on sygnal_zmiany_rpm.
  - Input changes at any other time are ignored.
- Offsets: off_k = (P × k) >> log2(N_CYL), truncated, so off_0 = 0.
- States:
  - IDLE: prescaler, all licznik, zliczanie_obrotow, aktywny and znacznik_gmp are 0.
    - rozruch=1 with taktowanie_na_stopien≠0 → latch P, go to RUN, set aktywny[0]=1.
    - rozruch=1 with taktowanie_na_stopien=0 → stay in IDLE.
  - RUN: the prescaler counts 0..PRESC−1. When it reaches PRESC−1 it asserts tick and returns to 0.
- On tick, cylinder 0 increments its counter. At P−1 it wraps to 0, increments zliczanie_obrotow (modulo 2^REV_W) and pulses znacznik_gmp[0].
- Cylinder k>0:
  - Activation: aktywny[k] goes high, with counter 0, on the edge where cylinder 0's counter becomes off_k.
  - Counting: once active, it counts and wraps exactly like cylinder 0, on the same tick.
  - Invariant: while active, licznik_k = (licznik_0 − off_k) mod P.
- Priority within a clock: zatrzymanie > sygnal_zmiany_rpm > tick.
  - zatrzymanie → IDLE, with every output cleared on the next edge.
  - sygnal_zmiany_rpm in RUN → relatch P, clear the prescaler and all counters, set aktywny = 1 (cylinder 0 only), stay in RUN.
  - If the new taktowanie_na_stopien = 0 at resync → go to IDLE instead.
  - A tick coinciding with either request is discarded.
- A wrap and an activation on the same tick are both applied.
- zliczanie_obrotow wraps silently at 2^REV_W.

## Timing
- Reset: all outputs 0, state IDLE. Reset takes effect immediately when asserted; release is synchronised to clk.
- Rozruch sampled at edge E0: from E0, state = RUN and prescaler = 0.
- licznik_0 = c holds from edge E0 + c×PRESC.
- First wrap of cylinder 0 is at E0 + P×PRESC.
- znacznik_gmp is high for exactly the clock following the wrap edge.
- Cylinder k activates at E0 + off_k×PRESC.
- sygnal_zmiany_rpm at edge R: counters are 0 from R. The next increment of cylinder 0 is at R + PRESC.
- Outputs are registered; no combinational input-to-output path.

## Configuration
- ODLICZANIE_ZNACZNIK_GMP_EN defined: znacznik_gmp is generated as described.
- Not defined: znacznik_gmp is tied to 0 and its wrap-detect registers are not built. All other behaviour is identical.

## Test plan
All scenarios use PRESC=4, N_CYL=4, taktowanie_na_stopien=1 (P=720), so off = 0/180/360/540.
- Start: rozruch pulse at E0 → licznik_0=1 at E0+4; aktywny=0011 at E0+720; aktywny=1111 at E0+2160; licznik_3=0 at that edge.
- Wrap: run to E0+2880 → licznik_0=0, zliczanie_obrotow_0=1, znacznik_gmp[0] high for one clock. licznik_1=540 at that edge.
- Resync mid-cycle: at licznik_0=300, set taktowanie_na_stopien=2 and pulse sygnal_zmiany_rpm → all counters 0, aktywny=0001. Cylinder 1 activates when licznik_0 = 360; cylinder 0 wraps after 1440 ticks.
- Priority: zatrzymanie and sygnal_zmiany_rpm on the same clock → IDLE, all outputs 0.
- Zero period: rozruch with taktowanie_na_stopien=0 → stays in IDLE. Asynchronous rst_n assertion mid-RUN → outputs 0 immediately.
- Build without ODLICZANIE_ZNACZNIK_GMP_EN: rerun the wrap scenario → counters identical, znacznik_gmp constant 0.

Source files
------------

// File: rtl/odliczanie_n_cylindrow.sv
// ---------------------------------------------------------------------------
// odliczanie_n_cylindrow
//
// Crank-angle timebase for an N-cylinder four-stroke engine. A prescaler turns
// the clock into angle ticks. Cylinder 0 counts one 720 degree cycle of
// P = taktowanie_na_stopien * 720 ticks. Cylinder k starts counting once
// cylinder 0 reaches its phase offset off_k = (P * k) >> log2(N_CYL).
//
// Optional feature macro: ODLICZANIE_ZNACZNIK_GMP_EN
//   defined     - znacznik_gmp pulses for one clock after each cylinder wrap
//   not defined - znacznik_gmp is tied to 0 and no wrap-flag flops are built
//
// Ports:
//   clk                   - sole clock, rising edge
//   rst_n                 - asynchronous active-low reset; release is synchronised to clk
//   rozruch               - start request, level-sampled while idle
//   zatrzymanie           - stop request, highest priority
//   sygnal_zmiany_rpm     - relatch the period and restart all cylinders
//   taktowanie_na_stopien - angle ticks per degree
//   licznik               - packed angle counters, cylinder k at [k*TICK_W +: TICK_W]
//   zliczanie_obrotow     - packed completed-cycle counters, cylinder k at [k*REV_W +: REV_W]
//   aktywny               - per-cylinder "counter running" flags
//   znacznik_gmp          - per-cylinder one-clock cycle-wrap pulse
// ---------------------------------------------------------------------------
module odliczanie_n_cylindrow #(
  parameter int N_CYL  = 4,
  parameter int PRESC  = 1000,
  parameter int TPD_W  = 9,
  parameter int TICK_W = 29,
  parameter int REV_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rozruch,
  input  logic                      zatrzymanie,
  input  logic                      sygnal_zmiany_rpm,
  input  logic [TPD_W-1:0]          taktowanie_na_stopien,
  output logic [N_CYL*TICK_W-1:0]   licznik,
  output logic [N_CYL*REV_W-1:0]    zliczanie_obrotow,
  output logic [N_CYL-1:0]          aktywny,
  output logic [N_CYL-1:0]          znacznik_gmp
);

  localparam int PER_W = TPD_W + 10;
  localparam int PS_W  = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int SH    = (N_CYL > 1) ? $clog2(N_CYL) : 0;
  localparam int OFF_W = PER_W + SH + 1;

  localparam logic [PS_W-1:0]   PRESC_LAST = PS_W'(PRESC - 32'd1);
  localparam logic [PS_W-1:0]   PS_JEDEN   = PS_W'(1'b1);
  localparam logic [TICK_W-1:0] JEDEN      = TICK_W'(1'b1);
  localparam logic [REV_W-1:0]  REV_JEDEN  = REV_W'(1'b1);
  localparam logic [N_CYL-1:0]  AKT_START  = N_CYL'(1'b1);

  typedef enum logic [0:0] {
    STAN_IDLE = 1'b0,
    STAN_RUN  = 1'b1
  } stan_t;

  logic [1:0]                         rst_sync_d, rst_sync_q;
  logic                               rst_int_n;

  stan_t                              stan_d, stan_q;
  logic [PS_W-1:0]                    presc_d, presc_q;
  logic [PER_W-1:0]                   period_d, period_q;
  logic [N_CYL-1:0][TICK_W-1:0]       licz_d, licz_q;
  logic [N_CYL-1:0][REV_W-1:0]        rev_d, rev_q;
  logic [N_CYL-1:0]                   akt_d, akt_q;

  logic [PER_W-1:0]                   new_period_s;
  logic                               tps_nz_s;
  logic                               tick_s;
  logic [TICK_W-1:0]                  last_s;
  logic [N_CYL-1:0]                   wrap_s;
  logic [TICK_W-1:0]                  licz0_next_s;
  logic [N_CYL-1:0][TICK_W-1:0]       off_s;

  // Reset synchroniser: next value of the release shift chain.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchroniser flops: assert immediately, release after two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Period candidate, tick strobe, wrap detect and phase offsets.
  always_comb begin
    new_period_s = PER_W'(taktowanie_na_stopien) * PER_W'(10'd720);
    tps_nz_s     = (taktowanie_na_stopien != {TPD_W{1'b0}});
    // A tick landing on a stop or resync request is discarded.
    tick_s       = (stan_q == STAN_RUN) && !zatrzymanie && !sygnal_zmiany_rpm &&
                   (presc_q == PRESC_LAST);
    last_s       = TICK_W'(period_q) - JEDEN;
    for (int k = 0; k < N_CYL; k++) begin
      wrap_s[k] = akt_q[k] && (licz_q[k] == last_s);
      off_s[k]  = TICK_W'((OFF_W'(period_q) * OFF_W'(k)) >> SH);
    end
    // Value cylinder 0 takes on this tick; activation compares against it.
    licz0_next_s = wrap_s[0] ? {TICK_W{1'b0}} : (licz_q[0] + JEDEN);
  end

  // Next-state logic for the run/idle machine and all counters.
  always_comb begin
    stan_d   = stan_q;
    presc_d  = presc_q;
    period_d = period_q;
    licz_d   = licz_q;
    rev_d    = rev_q;
    akt_d    = akt_q;
    case (stan_q)
      STAN_IDLE: begin
        presc_d = '0;
        licz_d  = '0;
        rev_d   = '0;
        akt_d   = '0;
        if (rozruch && !zatrzymanie && tps_nz_s) begin
          stan_d   = STAN_RUN;
          period_d = new_period_s;
          akt_d    = AKT_START;
        end else begin
          stan_d   = STAN_IDLE;
        end
      end
      STAN_RUN: begin
        if (zatrzymanie) begin
          stan_d  = STAN_IDLE;
          presc_d = '0;
          licz_d  = '0;
          rev_d   = '0;
          akt_d   = '0;
        end else if (sygnal_zmiany_rpm) begin
          presc_d  = '0;
          licz_d   = '0;
          rev_d    = '0;
          period_d = new_period_s;
          if (tps_nz_s) begin
            stan_d = STAN_RUN;
            akt_d  = AKT_START;
          end else begin
            stan_d = STAN_IDLE;
            akt_d  = '0;
          end
        end else if (tick_s) begin
          presc_d = '0;
          for (int k = 0; k < N_CYL; k++) begin
            if (akt_q[k]) begin
              if (wrap_s[k]) begin
                licz_d[k] = '0;
                rev_d[k]  = rev_q[k] + REV_JEDEN;
              end else begin
                licz_d[k] = licz_q[k] + JEDEN;
              end
            end else if (licz0_next_s == off_s[k]) begin
              // Activation lands with counter 0 on the edge cylinder 0 hits off_k.
              akt_d[k]  = 1'b1;
              licz_d[k] = '0;
              rev_d[k]  = '0;
            end else begin
              akt_d[k]  = akt_q[k];
            end
          end
        end else begin
          presc_d = presc_q + PS_JEDEN;
        end
      end
      default: begin
        stan_d  = STAN_IDLE;
        presc_d = '0;
        licz_d  = '0;
        rev_d   = '0;
        akt_d   = '0;
      end
    endcase
  end

  // State machine and counter registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      stan_q   <= STAN_IDLE;
      presc_q  <= '0;
      period_q <= '0;
      licz_q   <= '0;
      rev_q    <= '0;
      akt_q    <= '0;
    end else begin
      stan_q   <= stan_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      licz_q   <= licz_d;
      rev_q    <= rev_d;
      akt_q    <= akt_d;
    end
  end

  assign licznik           = licz_q;
  assign zliczanie_obrotow = rev_q;
  assign aktywny           = akt_q;

`ifdef ODLICZANIE_ZNACZNIK_GMP_EN
  logic [N_CYL-1:0] gmp_d, gmp_q;

  // Wrap flag: set on the tick that wraps a cylinder, cleared one clock later.
  always_comb begin
    for (int k = 0; k < N_CYL; k++) begin
      gmp_d[k] = tick_s && wrap_s[k];
    end
  end

  // Wrap flag registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      gmp_q <= '0;
    end else begin
      gmp_q <= gmp_d;
    end
  end

  assign znacznik_gmp = gmp_q;
`else
  assign znacznik_gmp = '0;
`endif

endmodule

// File: tb/tb_odliczanie_n_cylindrow.sv
// Scoreboard bench: stimulus pushes hand-computed snapshots tagged with the
// clock edge they belong to; a negedge monitor pops and compares them.
module tb_odliczanie_n_cylindrow;

  localparam int N_CYL = 4, PRESC = 4, TPD_W = 9, TICK_W = 29, REV_W = 4;
`ifdef ODLICZANIE_ZNACZNIK_GMP_EN
  localparam logic GMP_EN = 1'b1;
`else
  localparam logic GMP_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    rozruch = 1'b0;
  logic                    zatrzymanie = 1'b0;
  logic                    sygnal_zmiany_rpm = 1'b0;
  logic [TPD_W-1:0]        taktowanie_na_stopien = '0;
  logic [N_CYL*TICK_W-1:0] licznik;
  logic [N_CYL*REV_W-1:0]  zliczanie_obrotow;
  logic [N_CYL-1:0]        aktywny;
  logic [N_CYL-1:0]        znacznik_gmp;

  odliczanie_n_cylindrow #(
    .N_CYL(N_CYL), .PRESC(PRESC), .TPD_W(TPD_W), .TICK_W(TICK_W), .REV_W(REV_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rozruch(rozruch), .zatrzymanie(zatrzymanie),
    .sygnal_zmiany_rpm(sygnal_zmiany_rpm), .taktowanie_na_stopien(taktowanie_na_stopien),
    .licznik(licznik), .zliczanie_obrotow(zliczanie_obrotow),
    .aktywny(aktywny), .znacznik_gmp(znacznik_gmp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                      at;
    string                   nm;
    logic [N_CYL*TICK_W-1:0] licz;
    logic [N_CYL*REV_W-1:0]  rev;
    logic [N_CYL-1:0]        akt;
    logic [N_CYL-1:0]        gmp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(int at, string nm, int l0, int l1, int l2, int l3,
                      int r0, int r1, int r2, int r3, logic [3:0] akt, logic [3:0] gmp);
    exp_t e;
    e.at   = at;
    e.nm   = nm;
    e.licz = {29'(l3), 29'(l2), 29'(l1), 29'(l0)};
    e.rev  = {4'(r3), 4'(r2), 4'(r1), 4'(r0)};
    e.akt  = akt;
    e.gmp  = gmp & {4{GMP_EN}};
    sb.push_back(e);
  endtask

  task automatic push_zero(int at, string nm);
    push(at, nm, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compare every snapshot whose edge has just passed.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        cmp({sb[i].nm, ".licznik"}, 128'(licznik), 128'(sb[i].licz));
        cmp({sb[i].nm, ".obroty"}, 128'(zliczanie_obrotow), 128'(sb[i].rev));
        cmp({sb[i].nm, ".aktywny"}, 128'(aktywny), 128'(sb[i].akt));
        cmp({sb[i].nm, ".gmp"}, 128'(znacznik_gmp), 128'(sb[i].gmp));
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s missed: due cyc %0d now %0d", sb[i].nm, sb[i].at, cyc);
        sb.delete(i);
      end
    end
  end

  initial begin
    int e0, r, s, z, e1;

    push_zero(2, "reset_held");
    push_zero(6, "reset_idle");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Start with P = 720, offsets 0/180/360/540.
    wait_cyc(8);
    taktowanie_na_stopien = 9'd1;
    rozruch = 1'b1;
    e0 = cyc + 1;
    push(e0,        "start",      0,   0,   0,   0,   0, 0, 0, 0, 4'b0001, 4'b0000);
    push(e0 + 3,    "pre_tick",   0,   0,   0,   0,   0, 0, 0, 0, 4'b0001, 4'b0000);
    push(e0 + 4,    "tick1",      1,   0,   0,   0,   0, 0, 0, 0, 4'b0001, 4'b0000);
    push(e0 + 719,  "pre_akt1",   179, 0,   0,   0,   0, 0, 0, 0, 4'b0001, 4'b0000);
    push(e0 + 720,  "akt1",       180, 0,   0,   0,   0, 0, 0, 0, 4'b0011, 4'b0000);
    push(e0 + 724,  "cyl1_cnt",   181, 1,   0,   0,   0, 0, 0, 0, 4'b0011, 4'b0000);
    push(e0 + 1440, "akt2",       360, 180, 0,   0,   0, 0, 0, 0, 4'b0111, 4'b0000);
    push(e0 + 2160, "akt3",       540, 360, 180, 0,   0, 0, 0, 0, 4'b1111, 4'b0000);
    push(e0 + 2879, "pre_wrap",   719, 539, 359, 179, 0, 0, 0, 0, 4'b1111, 4'b0000);
    push(e0 + 2880, "wrap0",      0,   540, 360, 180, 1, 0, 0, 0, 4'b1111, 4'b0001);
    push(e0 + 2881, "wrap0_end",  0,   540, 360, 180, 1, 0, 0, 0, 4'b1111, 4'b0000);
    push(e0 + 2884, "post_wrap",  1,   541, 361, 181, 1, 0, 0, 0, 4'b1111, 4'b0000);
    push(e0 + 3600, "wrap1",      180, 0,   540, 360, 1, 1, 0, 0, 4'b1111, 4'b0010);
    push(e0 + 4080, "pre_resync", 300, 120, 660, 480, 1, 1, 0, 0, 4'b1111, 4'b0000);
    @(negedge clk);
    rozruch = 1'b0;

    // Resync at licznik_0 = 300 to P = 1440, offsets 0/360/720/1080.
    wait_cyc(e0 + 4080);
    taktowanie_na_stopien = 9'd2;
    sygnal_zmiany_rpm = 1'b1;
    r = cyc + 1;
    push(r,        "resync",       0,    0,    0,   0,   0, 0, 0, 0, 4'b0001, 4'b0000);
    push(r + 3,    "rs_pre_tick",  0,    0,    0,   0,   0, 0, 0, 0, 4'b0001, 4'b0000);
    push(r + 4,    "rs_tick1",     1,    0,    0,   0,   0, 0, 0, 0, 4'b0001, 4'b0000);
    push(r + 1439, "rs_pre_akt1",  359,  0,    0,   0,   0, 0, 0, 0, 4'b0001, 4'b0000);
    push(r + 1440, "rs_akt1",      360,  0,    0,   0,   0, 0, 0, 0, 4'b0011, 4'b0000);
    push(r + 5759, "rs_pre_wrap",  1439, 1079, 719, 359, 0, 0, 0, 0, 4'b1111, 4'b0000);
    push(r + 5760, "rs_wrap0",     0,    1080, 720, 360, 1, 0, 0, 0, 4'b1111, 4'b0001);
    push(r + 5761, "rs_wrap0_end", 0,    1080, 720, 360, 1, 0, 0, 0, 4'b1111, 4'b0000);
    @(negedge clk);
    sygnal_zmiany_rpm = 1'b0;
    taktowanie_na_stopien = 9'd7;   // not latched: no resync or start

    // Stop and resync on the same clock: stop wins.
    wait_cyc(r + 5770);
    zatrzymanie = 1'b1;
    sygnal_zmiany_rpm = 1'b1;
    taktowanie_na_stopien = 9'd1;
    s = cyc + 1;
    push_zero(s, "prio_stop");
    push_zero(s + 8, "prio_idle");
    @(negedge clk);
    zatrzymanie = 1'b0;
    sygnal_zmiany_rpm = 1'b0;

    // Start with zero period: stays idle.
    wait_cyc(s + 10);
    taktowanie_na_stopien = 9'd0;
    rozruch = 1'b1;
    z = cyc + 1;
    push_zero(z, "zero_p");
    push_zero(z + 8, "zero_p_idle");
    wait_cyc(z + 9);
    rozruch = 1'b0;

    // Async reset mid-run.
    wait_cyc(z + 12);
    taktowanie_na_stopien = 9'd1;
    rozruch = 1'b1;
    e1 = cyc + 1;
    push(e1,      "restart",   0,  0, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b0000);
    push(e1 + 48, "restart12", 12, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 4'b0000);
    @(negedge clk);
    rozruch = 1'b0;
    wait_cyc(e1 + 50);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst.licznik", 128'(licznik), 128'd0);
    cmp("async_rst.obroty", 128'(zliczanie_obrotow), 128'd0);
    cmp("async_rst.aktywny", 128'(aktywny), 128'd0);
    cmp("async_rst.gmp", 128'(znacznik_gmp), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_zero(cyc + 4, "after_rst");

    wait_cyc(e1 + 60);
    foreach (sb[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s never checked (due cyc %0d)", sb[i].nm, sb[i].at);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
